// File: rtl/decode_stage_pkg.sv
// Shared types for the RV32I-subset decode stage: ALU ops, opcode/funct encodings,
// scoreboard slot layout and the funct3 -> ALU op mapping shared by OP and OP-IMM.
package decode_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_XOR   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_AND   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       writeback;
    logic       is_load;
  } sb_entry_t;

  // sub_ok separates OP (alt funct7 selects SUB) from OP-IMM (imm bits alias funct7)
  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt,
                                          input logic sub_ok);
    case (f3)
      F3_ADD_SUB: return (alt && sub_ok) ? ALU_SUB : ALU_ADD;
      F3_SLL:     return ALU_SLL;
      F3_SLT:     return ALU_SLT;
      F3_SLTU:    return ALU_SLTU;
      F3_XOR:     return ALU_XOR;
      F3_SR:      return alt ? ALU_SRA : ALU_SRL;
      F3_OR:      return ALU_OR;
      default:    return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_instr_decode.sv
// Combinational instruction decoder: fields, immediate, ALU op, source usage, illegal.
// Zero latency; no flow control.
module instr_decode
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] imm_o,
  output alu_op_t         alu_op_o,
  output logic            alu_rs2_reg_o,
  output logic            is_load_o,
  output logic            is_store_o,
  output logic            writeback_o,
  output logic            illegal_o,
  output logic            rs1_used_o,
  output logic            rs2_used_o
);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       wb, ill;

  assign opcode = instr_i[6:0];
  assign rd_o   = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1_o  = instr_i[19:15];
  assign rs2_o  = instr_i[24:20];
  assign funct7 = instr_i[31:25];

  always_comb begin
    alu_op_o      = ALU_ADD;
    imm_o         = '0;
    alu_rs2_reg_o = 1'b0;
    is_load_o     = 1'b0;
    is_store_o    = 1'b0;
    rs1_used_o    = 1'b0;
    rs2_used_o    = 1'b0;
    wb            = 1'b0;
    ill           = 1'b0;
    case (opcode)
      OPC_OP: begin
        rs1_used_o    = 1'b1;
        rs2_used_o    = 1'b1;
        alu_rs2_reg_o = 1'b1;
        wb            = 1'b1;
        alu_op_o      = alu_from_f3(funct3, funct7 == F7_ALT, 1'b1);
        ill = !((funct7 == F7_BASE) ||
                (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SR)));
      end
      OPC_OP_IMM: begin
        rs1_used_o = 1'b1;
        wb         = 1'b1;
        imm_o      = XLEN'($signed(instr_i[31:20]));
        alu_op_o   = alu_from_f3(funct3, funct7 == F7_ALT, 1'b0);
      end
      OPC_LOAD: begin
        if (funct3 == F3_LW) begin
          rs1_used_o = 1'b1;
          wb         = 1'b1;
          is_load_o  = 1'b1;
          imm_o      = XLEN'($signed(instr_i[31:20]));
        end else begin
          ill = 1'b1;
        end
      end
      OPC_STORE: begin
        if (funct3 == F3_SW) begin
          rs1_used_o = 1'b1;
          rs2_used_o = 1'b1;
          is_store_o = 1'b1;
          imm_o      = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
        end else begin
          ill = 1'b1;
        end
      end
      OPC_LUI: begin
        wb       = 1'b1;
        alu_op_o = ALU_PASSB;
        imm_o    = XLEN'($signed({instr_i[31:12], 12'b0}));
      end
      default: ill = 1'b1;
    endcase
    // an illegal instruction must look inert to the scoreboard and execute
    if (ill) begin
      alu_op_o      = ALU_ADD;
      imm_o         = '0;
      alu_rs2_reg_o = 1'b0;
      is_load_o     = 1'b0;
      is_store_o    = 1'b0;
      rs1_used_o    = 1'b0;
      rs2_used_o    = 1'b0;
      wb            = 1'b0;
    end
    writeback_o = wb && (rd_o != 5'd0);
    illegal_o   = ill;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode with forwarding scoreboard and load-use stall; 1 cycle latency.
// Holds D/EX and scoreboard while out_ready=0; in_ready drops on a load-use hazard.
module decode_stage
  import decode_pkg::*;
#(
  parameter  int XLEN      = 32,
  parameter  int FWD_DEPTH = 3,
  localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [4:0]       out_rs1_addr,
  output logic [4:0]       out_rs2_addr,
  output logic [4:0]       out_rd_addr,
  output logic [XLEN-1:0]  out_imm,
  output alu_op_t          out_alu_op,
  output logic             out_alu_rs2_reg,
  output logic             out_is_load,
  output logic             out_is_store,
  output logic             out_writeback,
  output logic             out_illegal,
  output logic [SEL_W-1:0] out_rs1_fwd,
  output logic [SEL_W-1:0] out_rs2_fwd
);

  logic [4:0]      dec_rs1, dec_rs2, dec_rd;
  logic [XLEN-1:0] dec_imm;
  alu_op_t         dec_alu_op;
  logic            dec_rs2_reg, dec_is_load, dec_is_store, dec_wb, dec_illegal;
  logic            dec_rs1_used, dec_rs2_used;

  instr_decode #(.XLEN(XLEN)) u_dec (
    .instr_i      (in_instr),
    .rs1_o        (dec_rs1),
    .rs2_o        (dec_rs2),
    .rd_o         (dec_rd),
    .imm_o        (dec_imm),
    .alu_op_o     (dec_alu_op),
    .alu_rs2_reg_o(dec_rs2_reg),
    .is_load_o    (dec_is_load),
    .is_store_o   (dec_is_store),
    .writeback_o  (dec_wb),
    .illegal_o    (dec_illegal),
    .rs1_used_o   (dec_rs1_used),
    .rs2_used_o   (dec_rs2_used)
  );

  // sb_q[1] mirrors the D/EX register; older producers shift toward FWD_DEPTH
  sb_entry_t        sb_q [1:FWD_DEPTH];
  logic             valid_q, rs2_reg_q, is_load_q, is_store_q, wb_q, illegal_q;
  logic [4:0]       rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0]  imm_q;
  alu_op_t          alu_op_q;
  logic [SEL_W-1:0] rs1_fwd_q, rs2_fwd_q, rs1_fwd_d, rs2_fwd_d;
  logic             adv, hazard, accept;

  assign adv      = out_ready || !valid_q;
  assign in_ready = !rst && (flush || (adv && !hazard));
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    rs1_fwd_d = '0;
    rs2_fwd_d = '0;
    // walk oldest to newest so the nearest producer overwrites
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (sb_q[k].valid && sb_q[k].writeback) begin
        if (dec_rs1_used && dec_rs1 != 5'd0 && sb_q[k].rd == dec_rs1) rs1_fwd_d = SEL_W'(k);
        if (dec_rs2_used && dec_rs2 != 5'd0 && sb_q[k].rd == dec_rs2) rs2_fwd_d = SEL_W'(k);
      end
    end
    hazard = sb_q[1].valid && sb_q[1].is_load && sb_q[1].writeback &&
             ((dec_rs1_used && sb_q[1].rd == dec_rs1) ||
              (dec_rs2_used && sb_q[1].rd == dec_rs2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      alu_op_q   <= ALU_ADD;
      rs2_reg_q  <= 1'b0;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      wb_q       <= 1'b0;
      illegal_q  <= 1'b0;
      rs1_fwd_q  <= '0;
      rs2_fwd_q  <= '0;
      for (int k = 1; k <= FWD_DEPTH; k++) sb_q[k] <= '0;
    end else if (flush || adv) begin
      valid_q <= accept;
      if (accept) begin
        rs1_q      <= dec_rs1;
        rs2_q      <= dec_rs2;
        rd_q       <= dec_rd;
        imm_q      <= dec_imm;
        alu_op_q   <= dec_alu_op;
        rs2_reg_q  <= dec_rs2_reg;
        is_load_q  <= dec_is_load;
        is_store_q <= dec_is_store;
        wb_q       <= dec_wb;
        illegal_q  <= dec_illegal;
        rs1_fwd_q  <= rs1_fwd_d;
        rs2_fwd_q  <= rs2_fwd_d;
      end
      sb_q[1] <= '{valid: accept, rd: dec_rd, writeback: dec_wb, is_load: dec_is_load};
      // a flushed D/EX entry never produced a result, so a bubble moves down instead
      for (int k = 2; k <= FWD_DEPTH; k++) sb_q[k] <= (k == 2 && flush) ? '0 : sb_q[k-1];
    end
  end

  assign out_valid       = valid_q;
  assign out_rs1_addr    = rs1_q;
  assign out_rs2_addr    = rs2_q;
  assign out_rd_addr     = rd_q;
  assign out_imm         = imm_q;
  assign out_alu_op      = alu_op_q;
  assign out_alu_rs2_reg = rs2_reg_q;
  assign out_is_load     = is_load_q;
  assign out_is_store    = is_store_q;
  assign out_writeback   = wb_q;
  assign out_illegal     = illegal_q;
  assign out_rs1_fwd     = rs1_fwd_q;
  assign out_rs2_fwd     = rs2_fwd_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage with hand-computed expectations.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_instr;
  logic        in_ready, out_valid, out_alu_rs2_reg, out_is_load, out_is_store;
  logic        out_writeback, out_illegal;
  logic [4:0]  out_rs1_addr, out_rs2_addr, out_rd_addr;
  logic [31:0] out_imm;
  alu_op_t     out_alu_op;
  logic [1:0]  out_rs1_fwd, out_rs2_fwd;

  int checks = 0;
  int errors = 0;
  int st;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .FWD_DEPTH(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr),
    .out_imm(out_imm), .out_alu_op(out_alu_op), .out_alu_rs2_reg(out_alu_rs2_reg),
    .out_is_load(out_is_load), .out_is_store(out_is_store), .out_writeback(out_writeback),
    .out_illegal(out_illegal), .out_rs1_fwd(out_rs1_fwd), .out_rs2_fwd(out_rs2_fwd)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [4:0] rd, rs1, rs2);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, OPC_OP_IMM};
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, OPC_LOAD};
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] rs2, rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
  endfunction
  function automatic logic [31:0] add(input logic [4:0] rd, rs1, rs2);
    return r_op(7'b0000000, 3'b000, rd, rs1, rs2);
  endfunction

  // present ins, wait (bounded) until accepted; returns at the negedge after the accept edge
  task automatic send(input logic [31:0] ins, output int stalls);
    int n = 0;
    in_valid = 1'b1;
    in_instr = ins;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("accept", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    stalls = n;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_rd", out_rd_addr, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_wb", out_writeback, 0);
    chk("rst_fwd", {out_rs1_fwd, out_rs2_fwd}, 0);
    rst = 1'b0;
    #1 chk("post_rst_ready", in_ready, 1);

    // back-to-back forwarding
    send(addi(5'd1, 5'd0, 12'd5), st);
    chk("addi_valid", out_valid, 1);
    chk("addi_rd", out_rd_addr, 1);
    chk("addi_imm", out_imm, 5);
    chk("addi_wb", out_writeback, 1);
    chk("addi_b_imm", out_alu_rs2_reg, 0);
    chk("addi_fwd", out_rs1_fwd, 0);
    send(add(5'd2, 5'd1, 5'd1), st);
    chk("add_stalls", st, 0);
    chk("add_rs1_fwd", out_rs1_fwd, 1);
    chk("add_rs2_fwd", out_rs2_fwd, 1);
    chk("add_b_reg", out_alu_rs2_reg, 1);

    // load-use: one bubble then distance-2 forward
    send(lw(5'd3, 5'd1, 12'd0), st);
    chk("lw_is_load", out_is_load, 1);
    chk("lw_rs1_fwd", out_rs1_fwd, 2);
    in_valid = 1'b1;
    in_instr = add(5'd4, 5'd3, 5'd0);
    #1 chk("lu_ready_low", in_ready, 0);
    @(negedge clk);
    chk("lu_bubble", out_valid, 0);
    #1 chk("lu_ready_high", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("lu_valid", out_valid, 1);
    chk("lu_rd", out_rd_addr, 4);
    chk("lu_rs1_fwd", out_rs1_fwd, 2);
    chk("lu_rs2_fwd", out_rs2_fwd, 0);

    // newest producer wins; distance 3 still visible; distance 4 is not
    send(addi(5'd5, 5'd0, 12'd1), st);
    send(addi(5'd5, 5'd0, 12'd2), st);
    send(addi(5'd5, 5'd0, 12'd3), st);
    send(add(5'd8, 5'd5, 5'd0), st);
    chk("d1_fwd", out_rs1_fwd, 1);
    send(addi(5'd5, 5'd0, 12'd7), st);
    send(addi(5'd9, 5'd0, 12'd0), st);
    send(addi(5'd10, 5'd0, 12'd0), st);
    send(add(5'd8, 5'd5, 5'd0), st);
    chk("d3_fwd", out_rs1_fwd, 3);
    send(addi(5'd5, 5'd0, 12'd7), st);
    send(addi(5'd9, 5'd0, 12'd0), st);
    send(addi(5'd10, 5'd0, 12'd0), st);
    send(addi(5'd11, 5'd0, 12'd0), st);
    send(add(5'd8, 5'd5, 5'd0), st);
    chk("d4_fwd", out_rs1_fwd, 0);

    // x0 never written or forwarded
    send(addi(5'd0, 5'd0, 12'd1), st);
    chk("x0_wb", out_writeback, 0);
    send(add(5'd6, 5'd0, 5'd0), st);
    chk("x0_fwd", {out_rs1_fwd, out_rs2_fwd}, 0);

    // stall hold for 3 cycles keeps bundle and scoreboard
    send(addi(5'd12, 5'd0, 12'd9), st);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = add(5'd13, 5'd12, 5'd12);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_rd", out_rd_addr, 12);
      chk("stall_imm", out_imm, 9);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(add(5'd13, 5'd12, 5'd12), st);
    chk("rel_rd", out_rd_addr, 13);
    chk("rel_fwd", {out_rs1_fwd, out_rs2_fwd}, {2'd1, 2'd1});
    send(add(5'd14, 5'd12, 5'd0), st);
    chk("rel_fwd2", out_rs1_fwd, 2);

    // flush kills D/EX and drops the incoming reader
    send(add(5'd7, 5'd1, 5'd2), st);
    in_valid = 1'b1;
    in_instr = add(5'd15, 5'd7, 5'd7);
    flush = 1'b1;
    #1 chk("flush_ready", in_ready, 1);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    send(add(5'd16, 5'd7, 5'd0), st);
    chk("post_flush_rd", out_rd_addr, 16);
    chk("post_flush_fwd", out_rs1_fwd, 0);

    // decode of other formats
    send({7'b0000000, 5'd1, 5'd2, 3'b000, 5'd3, 7'b1100011}, st);
    chk("br_illegal", out_illegal, 1);
    chk("br_wb", out_writeback, 0);
    send(r_op(7'b0100000, 3'b000, 5'd17, 5'd1, 5'd2), st);
    chk("sub_op", out_alu_op, ALU_SUB);
    chk("sub_legal", out_illegal, 0);
    send(r_op(7'b0100000, 3'b101, 5'd17, 5'd1, 5'd2), st);
    chk("sra_op", out_alu_op, ALU_SRA);
    send(r_op(7'b0000001, 3'b000, 5'd17, 5'd1, 5'd2), st);
    chk("badf7_illegal", out_illegal, 1);
    send({20'h12345, 5'd18, OPC_LUI}, st);
    chk("lui_imm", out_imm, 32'h12345000);
    chk("lui_op", out_alu_op, ALU_PASSB);
    send(sw(5'd1, 5'd2, 12'hFFC), st);
    chk("sw_imm", out_imm, 32'hFFFFFFFC);
    chk("sw_store", out_is_store, 1);
    chk("sw_wb", out_writeback, 0);

    // async reset during a stall clears everything immediately
    send(addi(5'd19, 5'd0, 12'd3), st);
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_rd", out_rd_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    send(add(5'd20, 5'd19, 5'd0), st);
    chk("arst_fwd", out_rs1_fwd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
